// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
// Shared definitions for the memory responder: FSM state codes in the
// same 8-bit style as the CPU's own state codes.
package mem_responder_pkg;

    typedef enum logic [7:0] {
        ST_CLEAR = 8'h01,
        ST_LOAD  = 8'h02,
        ST_RUN   = 8'h04
    } state_t;

endpackage

// File: rtl/mem_responder_ram_sync.sv
// ram_sync
// Single-port-write synchronous RAM with a registered, read-first read port.
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset (clears only the read register)
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address, sampled every edge
//   rdata  registered read data (old word on read-during-write)
module ram_sync #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of the array in the same edge as the write yields
    // the pre-write word, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the CPU's single-port bus plus program loader.
// After reset it (optionally) clears the RAM, then accepts a program image
// over a valid/ready stream written from address 0, holding the CPU in reset
// until the image is complete. In RUN it serves CPU reads and writes.
// Optional feature macro: MEM_RESPONDER_CLEAR_EN (zero-fill sweep after reset).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mem_we, mem_addr, mem_data    CPU write enable / address / write data
//   mem_in                        registered read data to the CPU
//   load_valid, load_data,
//   load_last, load_ready         loader stream
//   cpu_hold                      high keeps the CPU in reset
//   load_count                    words loaded since reset (saturates at depth)
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] mem_in,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  cpu_hold,
    output logic [ADDR_WIDTH:0]   load_count
);

`ifdef MEM_RESPONDER_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    localparam state_t RESET_STATE = ST_LOAD;
`endif

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  xfer;
    logic                  ptr_step;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // load_ready depends only on state and rst, so there is no path from
    // load_valid back to load_ready.
    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        cpu_hold   = 1'b1;
        xfer       = 1'b0;
        ptr_step   = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = ptr;
        ram_wdata  = load_data;
        case (state)
`ifdef MEM_RESPONDER_CLEAR_EN
            ST_CLEAR: begin
                ram_we    = !rst;
                ram_wdata = '0;
                ptr_step  = 1'b1;
                if (ptr == '1) begin
                    state_nxt = ST_LOAD;
                end
            end
`endif
            ST_LOAD: begin
                load_ready = !rst;
                xfer       = load_valid && !rst;
                ram_we     = xfer;
                ptr_step   = xfer;
                // The last address ends loading even without load_last,
                // so the pointer never wraps over word 0.
                if (xfer && (load_last || ptr == '1)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                cpu_hold  = rst;
                ram_we    = mem_we && !rst;
                ram_waddr = mem_addr;
                ram_wdata = mem_data;
            end
            default: begin
                state_nxt = RESET_STATE;
            end
        endcase
    end

    // The clear sweep wraps the pointer back to 0 on its final step, which
    // is exactly where loading starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            load_count <= '0;
        end else begin
            if (ptr_step) begin
                ptr <= ptr + 1'b1;
            end
            if (xfer && load_count != FULL_COUNT) begin
                load_count <= load_count + 1'b1;
            end
        end
    end

    ram_sync #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (mem_addr),
        .rdata (mem_in)
    );

endmodule
